wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arbiter_pkg;

    // One queued secondary writeback: destination register plus data.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int WB_DEPTH_DEFAULT  = 4;
    localparam int WB_STARVE_DEFAULT = 8;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of wb_entry_t holding secondary writebacks, with a per-slot valid vector.
// Latency: a pushed entry is visible at head/entries the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk, reset (async, active-high), push/push_entry, pop, head, entries, valid, count, full, empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    // Payload storage carries no reset; the valid vector says what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            // Push and pop never target the same slot: that needs full (push
            // blocked) or empty (pop blocked).
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: primary pipeline writes win, secondary results queue and drain in idle slots.
// Latency: primary 0 cycles (combinational); secondary at least 1 cycle from accept to rf write.
// Backpressure: s_ready low when the queue is full; stall_req asks the pipeline for a bubble after sustained starvation.
// Ports: p_* primary write, s_* secondary valid/ready, rf_* register file port, pending scoreboard, count, stall_req.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = WB_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = WB_STARVE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_we,
    input  logic [4:0]               p_addr,
    input  logic [31:0]              p_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_addr,
    input  logic [31:0]              s_data,
    output logic                     rf_we,
    output logic [4:0]               rf_addr,
    output logic [31:0]              rf_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stall_req
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             in_entry;
    logic [DEPTH-1:0]      valid;
    logic                  full;
    logic                  empty;
    logic                  primary_wr;
    logic                  drain;
    logic                  push;
    logic [SW-1:0]         starve;
    logic [SW-1:0]         starve_nxt;

    // Writes to x0 are architecturally dead, so they neither write nor block.
    assign primary_wr = !reset && p_we && (p_addr != 5'd0);
    assign drain      = !primary_wr && !empty;
    // s_ready comes from registered occupancy only, so a same-cycle pop does not open a slot.
    assign s_ready    = !reset && !full;
    // x0 results complete the handshake but are not stored.
    assign push       = s_valid && s_ready && (s_addr != 5'd0);
    assign in_entry   = '{addr: s_addr, data: s_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (in_entry),
        .pop        (drain),
        .head       (head),
        .entries    (entries),
        .valid      (valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (primary_wr) begin
            rf_we   = 1'b1;
            rf_addr = p_addr;
            rf_data = p_data;
        end else if (drain) begin
            rf_we   = 1'b1;
            rf_addr = head.addr;
            rf_data = head.data;
        end
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending[entries[i].addr] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    // Counts consecutive cycles where queued work is blocked by the primary path.
    always_comb begin
        starve_nxt = starve;
        if (empty || drain) begin
            starve_nxt = '0;
        end else if (starve != LIMIT) begin
            starve_nxt = starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve    <= '0;
            stall_req <= 1'b0;
        end else begin
            starve    <= starve_nxt;
            stall_req <= (starve_nxt == LIMIT);
        end
    end

endmodule
